// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 opcodes, register constants and fetch FSM encoding
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } fetch_state_t;

  // Drop one byte into a little-endian 64-bit word at byte lane idx.
  function automatic logic [63:0] place_byte(input logic [63:0] w,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  b);
    logic [63:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/y86_fetch_unit_if.sv
// rtl/y86_fetch_unit_if.sv - byte-wide instruction memory request/valid bus
interface y86_fetch_unit_if;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - combinational icode to instruction length map
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       invalid
);

  always_comb begin
    len     = 4'd1;
    invalid = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET:             len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
      I_JXX, I_CALL:                    len = 4'd9;
      default: begin
        len     = 4'd1;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// rtl/y86_fetch_unit.sv - byte-serial Y86-64 instruction fetch stage
// Optional address bounds check: FETCH_BOUNDS_CHECK_EN.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] IMEM_SIZE = 64'd4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              pc_in,
  y86_fetch_unit_if.master         imem,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [63:0]              valP,
  output logic                     instr_valid,
  output logic                     imem_error
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   len_q, len_d;
  logic         req_q, req_d;
  logic [63:0]  addr_q, addr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q, ifun_d;
  logic [3:0]   ra_q, ra_d;
  logic [3:0]   rb_q, rb_d;
  logic [63:0]  valc_q, valc_d;
  logic [63:0]  valp_q, valp_d;
  logic         iv_q, iv_d;
  logic         err_q, err_d;

  logic [3:0]   dec_len;
  logic         dec_invalid;
  logic [3:0]   cur_len;
  logic [3:0]   next_cnt;
  logic [63:0]  next_addr;
  logic [2:0]   vidx;
  logic         byte_ok;

  // Only byte 0 is decoded straight off the bus; later bytes reuse len_q.
  y86_instr_len u_len (
    .icode   (imem.imem_rdata[7:4]),
    .len     (dec_len),
    .invalid (dec_invalid)
  );

  assign byte_ok   = (state_q == S_FETCH) && req_q && imem.imem_valid;
  assign cur_len   = (cnt_q == 4'd0) ? dec_len : len_q;
  assign next_cnt  = cnt_q + 4'd1;
  assign next_addr = pc_q + {60'd0, next_cnt};
  // 9-byte forms carry valC from byte 1, 10-byte forms from byte 2.
  assign vidx      = (len_q == 4'd9) ? (cnt_q[2:0] - 3'd1) : (cnt_q[2:0] - 3'd2);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    req_d   = req_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    iv_d    = iv_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = pc_in;
          cnt_d   = 4'd0;
          len_d   = 4'd1;
          addr_d  = pc_in;
          icode_d = 4'h0;
          ifun_d  = 4'h0;
          ra_d    = REG_NONE;
          rb_d    = REG_NONE;
          valc_d  = 64'd0;
          iv_d    = 1'b1;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = S_FETCH;
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_in >= IMEM_SIZE) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            valp_d  = pc_in + 64'd1;
            state_d = S_DONE;
          end
`endif
        end
      end

      S_FETCH: begin
        if (byte_ok) begin
          cnt_d  = next_cnt;
          addr_d = next_addr;
          if (cnt_q == 4'd0) begin
            icode_d = imem.imem_rdata[7:4];
            ifun_d  = imem.imem_rdata[3:0];
            len_d   = dec_len;
            iv_d    = ~dec_invalid;
          end else if ((len_q != 4'd9) && (cnt_q == 4'd1)) begin
            ra_d = imem.imem_rdata[7:4];
            rb_d = imem.imem_rdata[3:0];
          end else begin
            valc_d = place_byte(valc_q, vidx, imem.imem_rdata);
          end

          if (next_cnt == cur_len) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            valp_d  = pc_q + {60'd0, cur_len};
            state_d = S_DONE;
          end
`ifdef FETCH_BOUNDS_CHECK_EN
          else if (next_addr >= IMEM_SIZE) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            valp_d  = pc_q + {60'd0, cur_len};
            state_d = S_DONE;
          end
`endif
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 64'd0;
      cnt_q   <= 4'd0;
      len_q   <= 4'd1;
      req_q   <= 1'b0;
      addr_q  <= 64'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= REG_NONE;
      rb_q    <= REG_NONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      iv_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
    end
  end

`ifndef FETCH_BOUNDS_CHECK_EN
  logic unused_imem_size;
  assign unused_imem_size = ^IMEM_SIZE;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign icode          = icode_q;
  assign ifun           = ifun_q;
  assign rA             = ra_q;
  assign rB             = rb_q;
  assign valC           = valc_q;
  assign valP           = valp_q;
  assign instr_valid    = iv_q;
  assign imem_error     = err_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb/tb_y86_fetch_unit.sv - self-checking bench for y86_fetch_unit
module tb_y86_fetch_unit;
  import y86_pkg::*;

  localparam logic [63:0] IMEM_SIZE = 64'd4096;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        err;
    logic [3:0]  nbytes;
  } res_t;

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;
    int          waits;
    res_t        exp;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] pc_in;
  logic        busy, done, instr_valid, imem_error;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;

  int n_vec = 0;
  int n_err = 0;

  y86_fetch_unit_if bus ();

  y86_fetch_unit #(.IMEM_SIZE(IMEM_SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_in       (pc_in),
    .imem        (bus),
    .busy        (busy),
    .done        (done),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .instr_valid (instr_valid),
    .imem_error  (imem_error)
  );

  always #5 clk = ~clk;

  // Sparse byte memory with a configurable number of wait cycles per byte.
  logic [7:0]  mem [logic [63:0]];
  int          mem_gen = 0;
  int          wait_cfg = 0;
  bit          rand_wait = 1'b0;
  int          wcnt = 0;
  int          cur_wait = 0;
  int          acc_total = 0;
  int          wait_total = 0;
  logic [63:0] alog [0:1023];

  function automatic logic [7:0] rd(input logic [63:0] a, input int gen);
    rd = (gen >= 0 && mem.exists(a)) ? mem[a] : 8'h00;
  endfunction

  assign bus.imem_rdata = rd(bus.imem_addr, mem_gen);
  assign bus.imem_valid = bus.imem_req && (wcnt >= cur_wait);

  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_valid) begin
      alog[acc_total % 1024] <= bus.imem_addr;
      acc_total <= acc_total + 1;
      wcnt      <= 0;
      cur_wait  <= rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
    end else if (bus.imem_req) begin
      wcnt       <= wcnt + 1;
      wait_total <= wait_total + 1;
    end else begin
      wcnt     <= 0;
      cur_wait <= rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] vp,
                              input logic iv, input logic err, input logic [3:0] nb);
    res_t r;
    r.icode = ic; r.ifun = fn; r.ra = ra; r.rb = rb;
    r.valc = vc; r.valp = vp; r.iv = iv; r.err = err; r.nbytes = nb;
    return r;
  endfunction

  // Reference: length table, field split and optional bounds cut-off.
  function automatic res_t model(input logic [63:0] pc, input logic [79:0] b);
    res_t r;
    int   len;
    int   nf;
    logic [3:0] ic;
    ic = b[7:4];
    case (ic)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h3, 4'h4, 4'h5:       len = 10;
      4'h7, 4'h8:             len = 9;
      default:                len = 1;
    endcase
    nf = len;
`ifdef FETCH_BOUNDS_CHECK_EN
    nf = 0;
    while (nf < len && (pc + 64'(nf)) < IMEM_SIZE) nf++;
`endif
    r = mk(4'h0, 4'h0, REG_NONE, REG_NONE, 64'd0, 64'd0, 1'b1, 1'b0, 4'(nf));
    r.err = (nf < len);
    if (nf > 0) begin
      r.icode = ic;
      r.ifun  = b[3:0];
      r.iv    = (ic <= 4'hB);
    end
    for (int i = 1; i < nf; i++) begin
      if (len == 9) r.valc[8*(i-1) +: 8] = b[8*i +: 8];
      else if (i == 1) begin
        r.ra = b[15:12];
        r.rb = b[11:8];
      end else r.valc[8*(i-2) +: 8] = b[8*i +: 8];
    end
    r.valp = pc + ((nf == 0) ? 64'd1 : 64'(len));
    return r;
  endfunction

  task automatic fetch_check(input string nm, input logic [63:0] pc, input logic [79:0] b,
                             input int waits, input bit rnd, input res_t exp, input int exp_cyc);
    int a0, w0, cyc, ecyc;
    for (int i = 0; i < 10; i++) mem[pc + 64'(i)] = b[8*i +: 8];
    mem_gen++;
    wait_cfg  = waits;
    rand_wait = rnd;
    @(negedge clk);
    a0 = acc_total;
    w0 = wait_total;
    start = 1'b1;
    pc_in = pc;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " done_seen"}, 64'(done), 64'd1);
    ecyc = (exp_cyc >= 0) ? exp_cyc : int'(exp.nbytes) + (wait_total - w0) + 1;
    chk({nm, " done_cycle"}, 64'(cyc), 64'(ecyc));
    chk({nm, " icode"}, 64'(icode), 64'(exp.icode));
    chk({nm, " ifun"}, 64'(ifun), 64'(exp.ifun));
    chk({nm, " rA"}, 64'(rA), 64'(exp.ra));
    chk({nm, " rB"}, 64'(rB), 64'(exp.rb));
    chk({nm, " valC"}, valC, exp.valc);
    chk({nm, " valP"}, valP, exp.valp);
    chk({nm, " instr_valid"}, 64'(instr_valid), 64'(exp.iv));
    chk({nm, " imem_error"}, 64'(imem_error), 64'(exp.err));
    chk({nm, " bytes_read"}, 64'(acc_total - a0), 64'(exp.nbytes));
    for (int i = 0; i < int'(exp.nbytes) && i < (acc_total - a0); i++)
      chk({nm, " addr"}, alog[(a0 + i) % 1024], pc + 64'(i));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
    chk({nm, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc, a0;
    bit   seen;
    logic [79:0] rb;
    logic [63:0] rpc;

    vecs[0] = '{64'h0,   80'h10, 0, mk(4'h1,4'h0,4'hF,4'hF,64'h0,64'h1,1,0,1), 2};
    vecs[1] = '{64'h100, 80'h0123456789ABCDEFF330, 0,
                mk(4'h3,4'h0,4'hF,4'h3,64'h0123456789ABCDEF,64'h10A,1,0,10), 11};
    vecs[2] = '{64'h100, 80'h0123456789ABCDEFF330, 2,
                mk(4'h3,4'h0,4'hF,4'h3,64'h0123456789ABCDEF,64'h10A,1,0,10), 31};
    vecs[3] = '{64'h20,  80'h00000000000000010080, 0,
                mk(4'h8,4'h0,4'hF,4'hF,64'h100,64'h29,1,0,9), 10};
    vecs[4] = '{64'h20,  80'h00000000000000010074, 0,
                mk(4'h7,4'h4,4'hF,4'hF,64'h100,64'h29,1,0,9), 10};
    vecs[5] = '{64'h8,   80'hC0, 0, mk(4'hC,4'h0,4'hF,4'hF,64'h0,64'h9,0,0,1), 2};
    vecs[6] = '{64'h40,  80'h2360, 0, mk(4'h6,4'h0,4'h2,4'h3,64'h0,64'h42,1,0,2), 3};
    vecs[7] = '{64'h200, 80'h00000000000000081540, 1,
                mk(4'h4,4'h0,4'h1,4'h5,64'h8,64'h20A,1,0,10), 21};

    rst = 1'b1;
    start = 1'b0;
    pc_in = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst imem_addr", bus.imem_addr, 64'd0);
    chk("rst imem_error", 64'(imem_error), 64'd0);
    chk("rst regs", {48'd0, icode, ifun, rA, rB}, 64'h00FF);
    chk("rst valC", valC, 64'd0);
    chk("rst valP", valP, 64'd0);
    chk("rst instr_valid", 64'(instr_valid), 64'd1);

    for (int i = 0; i < 8; i++)
      fetch_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].bytes, vecs[i].waits, 1'b0,
                  vecs[i].exp, vecs[i].cyc);

    // start held high through busy and the done cycle must not refetch
    mem[64'h8] = 8'hC0;
    mem_gen++;
    wait_cfg = 0;
    rand_wait = 1'b0;
    @(negedge clk);
    a0 = acc_total;
    start = 1'b1;
    pc_in = 64'h8;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      pc_in = 64'h100;
      seen = done;
    end
    chk("busy_start done_cycle", 64'(cyc), 64'd2);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_start bytes", 64'(acc_total - a0), 64'd1);
    chk("busy_start idle", 64'(busy), 64'd0);
    chk("busy_start valP", valP, 64'h9);

    // reset in the 4th byte cycle of an irmovq
    for (int i = 0; i < 10; i++) mem[64'h100 + 64'(i)] = vecs[1].bytes[8*i +: 8];
    mem_gen++;
    @(negedge clk);
    start = 1'b1;
    pc_in = 64'h100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst imem_req", 64'(bus.imem_req), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst regs", {48'd0, icode, ifun, rA, rB}, 64'h00FF);
    chk("midrst valC", valC, 64'd0);
    chk("midrst valP", valP, 64'd0);
    chk("midrst imem_addr", bus.imem_addr, 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("midrst no_done", 64'(seen), 64'd0);

    // irmovq straddling the end of memory
`ifdef FETCH_BOUNDS_CHECK_EN
    fetch_check("bounds", 64'hFFA, vecs[1].bytes, 0, 1'b0,
                mk(4'h3,4'h0,4'hF,4'h3,64'h89ABCDEF,64'h1004,1,1,6), 7);
`else
    fetch_check("bounds", 64'hFFA, vecs[1].bytes, 0, 1'b0,
                mk(4'h3,4'h0,4'hF,4'h3,64'h0123456789ABCDEF,64'h1004,1,0,10), 11);
`endif
    fetch_check("after_bounds", 64'h0, 80'h10, 0, 1'b0, model(64'h0, 80'h10), 2);

    // randomized instructions against the model
    for (int t = 0; t < 40; t++) begin
      rb  = {$urandom, $urandom, $urandom};
      rpc = 64'($urandom_range(0, 4000));
      fetch_check($sformatf("rand%0d", t), rpc, rb, 0, t[0], model(rpc, rb), -1);
    end
    rb = 80'h8877665544332211F230;
    fetch_check("wrap", 64'hFFFF_FFFF_FFFF_FFFC, rb, 0, 1'b1,
                model(64'hFFFF_FFFF_FFFF_FFFC, rb), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/y86_fetch_unit.md
# y86_fetch_unit

Sequential instruction-fetch stage of the Y86-64 processor, sitting directly upstream of `pc_update`. On a start strobe it reads one instruction, one byte at a time, from a byte-wide instruction memory over a request/valid handshake, starting at the supplied PC. It splits the bytes into `icode`, `ifun`, `rA`, `rB` and `valC`, computes `valP`, and then pulses `done`. The `valP`/`valC`/`icode` outputs feed decode/execute and `pc_update`.

## Interface
- `IMEM_SIZE`, default 4096: instruction memory size in bytes; used only by the bounds check.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle strobe that begins a fetch at `pc_in`; ignored while `busy`=1.
- `pc_in`  in  64  address of the first instruction byte, sampled when `start` is accepted.
- `imem_req`  out  1  byte read request.
- `imem_addr`  out  64  byte address, stable while `imem_req`=1 and `imem_valid`=0.
- `imem_rdata`  in  8  returned byte, valid when `imem_valid`=1.
- `imem_valid`  in  1  read-data valid; may be asserted in the same cycle as `imem_req` (zero-wait).
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-cycle pulse when the outputs below are final.
- `icode`, `ifun`  out  4 each  opcode and function nibbles.
- `rA`, `rB`  out  4 each  register specifiers; 4'hF when the instruction has no register byte.
- `valC`  out  64  constant word, little-endian; 0 when absent.
- `valP`  out  64  `pc_in` + instruction length, modulo 2^64.
- `instr_valid`  out  1  0 when `icode` > 4'hB.
- `imem_error`  out  1  address out of range (only with the check compiled in).

## Operation
- Instruction length is decoded from the `icode` held in byte 0:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes.
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes.
  - 7 (jXX), 8 (call): 9 bytes.
  - Above B: 1 byte, `instr_valid`=0.
- Byte placement:
  - Byte 0 gives {`icode`, `ifun`} (high nibble, low nibble).
  - For 2- and 10-byte instructions, byte 1 gives {`rA`, `rB`}.
  - The next 8 bytes form `valC`, with the first byte as the LSB.
- FSM:
  - IDLE: `busy`=0. On `start`, latch `pc_in`, clear the byte counter, go to FETCH.
  - FETCH: `imem_req`=1, `imem_addr` = latched PC + counter. Each cycle with `imem_valid`=1 captures one byte and increments the counter. When the counter reaches the decoded length, go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- Outputs hold their last values in IDLE until the next DONE.
- Outputs are not guaranteed to be final during FETCH; consumers sample them only on `done`.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`, `done`, `imem_req`, `imem_error`: 0.
  - `imem_addr`, `valC`, `valP`: 0.
  - `icode`, `ifun`: 0.
  - `rA`, `rB`: 4'hF.
  - `instr_valid`: 1.
- `start` sampled in cycle 0 gives `imem_req`=1 from cycle 1.
- With zero-wait memory, an N-byte instruction pulses `done` in cycle N+1. Each memory wait cycle adds one cycle.
- `start` arriving in the same cycle as `done`, or while `busy`, is ignored.
- `rst` has priority over every other input. Reset mid-fetch aborts the fetch with no `done` pulse and deasserts `imem_req` in the following cycle.
- `imem_valid` while `imem_req`=0 is ignored.
- Address arithmetic wraps modulo 2^64.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined:
  - Before requesting any byte whose address is ≥ `IMEM_SIZE`, the block skips the request, sets `imem_error`=1, and goes straight to DONE.
  - `icode`, `ifun`, `rA`, `rB` and `valC` keep whatever bytes were already captured. `valP` = `pc_in` + decoded length, or + 1 if byte 0 was not fetched.
  - `imem_error` clears on the next accepted `start`.
- Not defined: no address check; `imem_error` is tied to 0.

## Structure
- Shared package `y86_pkg` holds:
  - the icode localparams (`I_HALT` … `I_POPQ`), shared with `pc_update` and decode;
  - the FSM state encoding;
  - `REG_NONE` = 4'hF.
- One sub-module, `y86_instr_len`: a combinational map from `icode` to length (1/2/9/10) and an invalid flag. It is reused by later pipeline work.

## Test plan
- nop (byte 0x10) at 0x0, zero-wait → `icode`=1, `rA`=`rB`=F, `valP`=0x1, `done` in cycle 2.
- irmovq at 0x100, bytes 30 F3 EF CD AB 89 67 45 23 01 → `icode`=3, `rA`=F, `rB`=3, `valC`=0x0123456789ABCDEF, `valP`=0x10A, `done` in cycle 11; with 2 wait cycles on every byte, `done` in cycle 31.
- call at 0x20, bytes 80 then 00 01 00 00 00 00 00 00 → `icode`=8, `valC`=0x100, `valP`=0x29. Repeat with jXX, bytes 74 …, giving `ifun`=4.
- byte 0xC0 at 0x8 → `instr_valid`=0, `valP`=0x9, `done` after 1 byte. A second `start` asserted while `busy` produces no extra fetch.
- `rst` asserted in the 4th byte cycle of an irmovq fetch → `imem_req`=0 and `busy`=0 in the following cycle, no `done`, outputs at their reset values.
- With `FETCH_BOUNDS_CHECK_EN` and `IMEM_SIZE`=16: irmovq at 0xA → 6 bytes read, then `imem_error`=1 and `done`; with the macro undefined, all 10 bytes are requested.
